// File: rtl/core_pkg.sv
// Shared definitions for the 2-bit-opcode core (mov/add/jump).
// Used by the fetch stage, the main control unit and the execute stage.
// Instruction layout: [7:6] opcode, [5:3] rd, [2:0] rs; jumps use [5:0] as an absolute target.
package core_pkg;

  localparam int unsigned INSTR_W   = 8;
  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned OPCODE_W  = 2;

  localparam logic [OPCODE_W-1:0] OP_MOV = 2'b00;
  localparam logic [OPCODE_W-1:0] OP_ADD = 2'b01;
  // Any opcode with this bit set is a jump (1x).
  localparam int unsigned OP_J_MSB = 1;

  // Field positions within an instruction word.
  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 6;
  localparam int unsigned RD_MSB  = 5;
  localparam int unsigned RD_LSB  = 3;
  localparam int unsigned RS_MSB  = 2;
  localparam int unsigned RS_LSB  = 0;
  localparam int unsigned JT_MSB  = 5;
  localparam int unsigned JT_LSB  = 0;

  function automatic logic is_jump(input logic [OPCODE_W-1:0] op);
    return op[OP_J_MSB];
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: Depth = 2**ADDR_W words of Width bits.
// Synchronous write, combinational read. Contents are never reset.
// A read and a write to the same address in one cycle return the old word;
// the new word is visible after the write edge.
// Ports:
//   clk_i   - rising-edge clock
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address
//   rdata_o - read data (combinational)
module instr_mem #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned Width  = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [Width-1:0]  rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage plus IF/ID pipeline register for the 5-stage mov/add/jump core.
// Holds the fetch PC, the loadable instruction memory and the IF/ID register.
// A taken jump (pc_src with a valid IF/ID entry) redirects the PC to the
// absolute target in the instruction and inserts exactly one bubble.
// Ports:
//   clk         - rising-edge clock
//   reset       - asynchronous active-low reset
//   stall       - hold PC and IF/ID this cycle (wins over pc_src)
//   pc_src      - from control unit: instruction in IF/ID is a jump
//   prog_we     - instruction-memory write enable
//   prog_addr   - instruction-memory write address
//   prog_data   - instruction-memory write data
//   pc          - current fetch PC
//   if_id_instr - registered instruction
//   if_id_pc    - PC of the registered instruction
//   if_id_valid - 1 = real instruction, 0 = bubble
//   opcode      - if_id_instr[7:6]
//   rd          - if_id_instr[5:3]
//   rs          - if_id_instr[2:0]
module instruction_fetch_stage #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned INSTR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               pc_src,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid,
  output logic [1:0]         opcode,
  output logic [2:0]         rd,
  output logic [2:0]         rs
);

  import core_pkg::OPC_MSB;
  import core_pkg::OPC_LSB;
  import core_pkg::RD_MSB;
  import core_pkg::RD_LSB;
  import core_pkg::RS_MSB;
  import core_pkg::RS_LSB;
  import core_pkg::JT_MSB;
  import core_pkg::JT_LSB;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
  logic [ADDR_W-1:0]  if_id_pc_q, if_id_pc_d;
  logic               if_id_valid_q, if_id_valid_d;
  logic [INSTR_W-1:0] fetch_data;

  instr_mem #(
    .ADDR_W(ADDR_W),
    .Width (INSTR_W)
  ) u_instr_mem (
    .clk_i  (clk),
    .we_i   (prog_we),
    .waddr_i(prog_addr),
    .wdata_i(prog_data),
    .raddr_i(pc_q),
    .rdata_o(fetch_data)
  );

  always_comb begin
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    if (stall) begin
      // Hold everything; a pending jump resolves on the first unstalled edge.
    end else if (pc_src && if_id_valid_q) begin
      // Taken jump: redirect and squash the wrong-path fetch into a bubble.
      pc_d          = ADDR_W'(if_id_instr_q[JT_MSB:JT_LSB]);
      if_id_instr_d = '0;
      if_id_pc_d    = '0;
      if_id_valid_d = 1'b0;
    end else begin
      pc_d          = pc_q + ADDR_W'(1);
      if_id_instr_d = fetch_data;
      if_id_pc_d    = pc_q;
      if_id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= '0;
      if_id_instr_q <= '0;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign pc          = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_valid = if_id_valid_q;
  assign opcode      = if_id_instr_q[OPC_MSB:OPC_LSB];
  assign rd          = if_id_instr_q[RD_MSB:RD_LSB];
  assign rs          = if_id_instr_q[RS_MSB:RS_LSB];

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          pc_src;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic [AW-1:0] pc;
  logic [7:0]    if_id_instr;
  logic [AW-1:0] if_id_pc;
  logic          if_id_valid;
  logic [1:0]    opcode;
  logic [2:0]    rd;
  logic [2:0]    rs;

  int checks = 0;
  int errors = 0;

  instruction_fetch_stage #(
    .ADDR_W (AW),
    .INSTR_W(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .pc_src     (pc_src),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .pc         (pc),
    .if_id_instr(if_id_instr),
    .if_id_pc   (if_id_pc),
    .if_id_valid(if_id_valid),
    .opcode     (opcode),
    .rd         (rd),
    .rs         (rs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          stall;
    logic          pc_src;
    logic [AW-1:0] pc;
    logic [7:0]    instr;
    logic [AW-1:0] ipc;
    logic          valid;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [AW-1:0] e_pc,
                           input logic [7:0] e_instr, input logic [AW-1:0] e_ipc,
                           input logic e_valid);
    logic [7:0] ei;
    ei = e_instr;
    chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
    chk({tag, ".instr"}, 32'(if_id_instr), 32'(ei));
    chk({tag, ".if_id_pc"}, 32'(if_id_pc), 32'(e_ipc));
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(e_valid));
    chk({tag, ".opcode"}, 32'(opcode), 32'(ei[7:6]));
    chk({tag, ".rd"}, 32'(rd), 32'(ei[5:3]));
    chk({tag, ".rs"}, 32'(rs), 32'(ei[2:0]));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step(input logic st, input logic ps);
    stall  = st;
    pc_src = ps;
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input logic [AW-1:0] a, input logic [7:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    stall     = 1'b0;
    pc_src    = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;

    // Program loaded while held in reset.
    write_mem(6'd0, 8'h0A);
    write_mem(6'd1, 8'h53);
    write_mem(6'd2, 8'hC5);  // jump 5
    write_mem(6'd3, 8'h11);
    write_mem(6'd4, 8'h22);
    write_mem(6'd5, 8'h4B);
    write_mem(6'd6, 8'h5E);
    write_mem(6'd7, 8'h88);  // jump 8
    write_mem(6'd8, 8'h33);
    write_mem(6'd9, 8'h84);  // jump 4
    write_mem(6'd62, 8'h6A);
    write_mem(6'd63, 8'h2D);
    chk_state("reset", 6'd0, 8'h00, 6'd0, 1'b0);

    //            stall pc_src  pc     instr  ipc    valid
    vecs[0]  = '{1'b0, 1'b0, 6'd1, 8'h0A, 6'd0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 6'd2, 8'h53, 6'd1, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 6'd3, 8'hC5, 6'd2, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 6'd3, 8'hC5, 6'd2, 1'b1};  // stall beats jump
    vecs[4]  = '{1'b1, 1'b1, 6'd3, 8'hC5, 6'd2, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 6'd5, 8'h00, 6'd0, 1'b0};  // jump resolves, bubble
    vecs[6]  = '{1'b0, 1'b1, 6'd6, 8'h4B, 6'd5, 1'b1};  // pc_src on bubble ignored
    vecs[7]  = '{1'b0, 1'b0, 6'd7, 8'h5E, 6'd6, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 6'd8, 8'h88, 6'd7, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 6'd8, 8'h00, 6'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 6'd9, 8'h33, 6'd8, 1'b1};

    reset = 1'b1;
    foreach (vecs[i]) begin
      step(vecs[i].stall, vecs[i].pc_src);
      chk_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].ipc, vecs[i].valid);
    end

    // Asynchronous reset between edges while pc=9.
    #2;
    reset = 1'b0;
    #1;
    chk_state("async_rst", 6'd0, 8'h00, 6'd0, 1'b0);
    @(posedge clk);
    #1;
    chk_state("rst_hold", 6'd0, 8'h00, 6'd0, 1'b0);
    reset = 1'b1;
    step(1'b0, 1'b0);
    chk_state("restart", 6'd1, 8'h0A, 6'd0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk_state("pre_coll", 6'd4, 8'h11, 6'd3, 1'b1);

    // Write to the address being fetched: IF/ID sees the old word.
    prog_we   = 1'b1;
    prog_addr = 6'd4;
    prog_data = 8'h77;
    step(1'b0, 1'b0);
    prog_we = 1'b0;
    chk_state("coll_old", 6'd5, 8'h22, 6'd4, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
    chk_state("pre_j4", 6'd9, 8'h33, 6'd8, 1'b1);
    step(1'b0, 1'b0);
    chk_state("j4_in_ifid", 6'd10, 8'h84, 6'd9, 1'b1);
    step(1'b0, 1'b1);
    chk_state("j4_bubble", 6'd4, 8'h00, 6'd0, 1'b0);
    step(1'b0, 1'b0);
    chk_state("coll_new", 6'd5, 8'h77, 6'd4, 1'b1);

    // Wrap-around: jump to 62 and run sequentially past 63.
    reset = 1'b0;
    write_mem(6'd0, 8'hFE);  // jump 62
    reset = 1'b1;
    step(1'b0, 1'b0);
    chk_state("wrap_j", 6'd1, 8'hFE, 6'd0, 1'b1);
    step(1'b0, 1'b1);
    chk_state("wrap_bub", 6'd62, 8'h00, 6'd0, 1'b0);
    step(1'b0, 1'b0);
    chk_state("wrap62", 6'd63, 8'h6A, 6'd62, 1'b1);
    step(1'b0, 1'b0);
    chk_state("wrap63", 6'd0, 8'h2D, 6'd63, 1'b1);
    step(1'b0, 1'b0);
    chk_state("wrap0", 6'd1, 8'hFE, 6'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
